// File: rtl/instr_encoder.sv
// RV32I instruction assembler: turns decoded fields into a 32-bit word, buffers
// accepted words in an in-order FIFO and counts rejected commands.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_class,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic            in_f7b5,
    input  logic [31:0]     in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            err_pulse,
    output logic [ERRW-1:0] err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [2:0] CLS_LOAD   = 3'd0;
    localparam logic [2:0] CLS_STORE  = 3'd1;
    localparam logic [2:0] CLS_OP     = 3'd2;
    localparam logic [2:0] CLS_OPIMM  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            err_pulse_q, err_pulse_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    logic [31:0] word;
    logic        rej;
    logic        fit12, fit_b, fit_j, fit_sh, f7_ok, is_shift;
    logic        accept, push, pop, full, empty;

    // Range checks as sign-extension tests: upper bits must all copy the top field bit.
    assign fit12    = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fit_b    = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign fit_j    = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    assign fit_sh   = ~(|in_imm[31:5]);
    assign f7_ok    = ~in_f7b5 | (in_funct3 == 3'b000) | (in_funct3 == 3'b101);
    assign is_shift = (in_funct3 == 3'b001) | (in_funct3 == 3'b101);

    always_comb begin
        word = '0;
        rej  = 1'b0;
        case (in_class)
            CLS_LOAD: begin
                word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
                rej  = ~fit12;
            end
            CLS_STORE: begin
                word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
                rej  = ~fit12;
            end
            CLS_OP: begin
                word = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
                rej  = ~f7_ok;
            end
            CLS_OPIMM: begin
                if (is_shift) begin
                    word = {1'b0, in_f7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
                    rej  = ~fit_sh | ~f7_ok;
                end else begin
                    word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
                    rej  = ~fit12;
                end
            end
            CLS_BRANCH: begin
                word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OPC_BRANCH};
                rej  = ~fit_b;
            end
            CLS_JAL: begin
                word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
                rej  = ~fit_j;
            end
            default: rej = 1'b1;
        endcase
    end

    // in_ready looks only at occupancy, so a full FIFO stalls even while popping.
    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign in_ready = ~full;
    assign accept   = in_valid & in_ready;
    assign push     = accept & ~rej;
    assign pop      = ~empty & out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        err_pulse_d = accept & rej;
        err_cnt_d   = err_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (accept && rej && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERRW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Storage needs no reset; occupancy gates what is visible.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= word;
    end

    assign out_valid = ~empty;
    assign out_instr = empty ? 32'h0 : mem_q[rd_ptr_q];
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal cases plus randomized
// traffic checked every cycle against a queue-based model.
module tb_instr_encoder;
    localparam int DEPTH = 4;
    localparam int ERRW  = 8;
    localparam int EMAX  = (1 << ERRW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_class = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_f7b5 = 1'b0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        err_pulse;
    logic [ERRW-1:0] err_count;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    instr_encoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    int          merr = 0;
    bit          mpulse = 1'b0;

    function automatic bit m_rej(logic [2:0] c, logic [2:0] f3, logic f7, logic [31:0] imm);
        int v;
        v = $signed(imm);
        case (c)
            3'd0, 3'd1: return (v < -2048) || (v > 2047);
            3'd2:       return f7 && (f3 != 3'd0) && (f3 != 3'd5);
            3'd3: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    return (v < 0) || (v > 31) || (f7 && f3 != 3'd5);
                return (v < -2048) || (v > 2047);
            end
            3'd4:       return (v < -4096) || (v > 4094) || (v % 2 != 0);
            3'd5:       return (v < -(1 << 20)) || (v > (1 << 20) - 2) || (v % 2 != 0);
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_enc(logic [2:0] c, logic [4:0] rd, logic [4:0] rs1,
                                          logic [4:0] rs2, logic [2:0] f3, logic f7,
                                          logic [31:0] imm);
        case (c)
            3'd0: return {imm[11:0], rs1, f3, rd, 7'b0000011};
            3'd1: return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            3'd2: return {1'b0, f7, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
            3'd3: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    return {1'b0, f7, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011};
                return {imm[11:0], rs1, f3, rd, 7'b0010011};
            end
            3'd4: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            3'd5: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit rdy, acc, rj, pp;
        if (rst) begin
            mq.delete();
            merr = 0;
            mpulse = 1'b0;
        end else begin
            rdy = (mq.size() < DEPTH);
            acc = in_valid && rdy;
            rj  = acc && m_rej(in_class, in_funct3, in_f7b5, in_imm);
            pp  = (mq.size() > 0) && out_ready;
            mpulse = rj;
            if (rj && merr < EMAX) merr++;
            if (pp) void'(mq.pop_front());
            if (acc && !rj) mq.push_back(m_enc(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("m_out_instr", out_instr, (mq.size() > 0) ? mq[0] : 32'h0);
            chk("m_err_pulse", 32'(err_pulse), 32'(mpulse));
            chk("m_err_count", 32'(err_count), 32'(merr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                           input logic [31:0] imm);
        in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_f7b5 = f7; in_imm = imm;
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm);
        bit ok, done;
        done = 1'b0;
        set_cmd(c, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            ok = in_ready;
            step();
            done = ok;
        end
        in_valid = 1'b0;
        if (!done) begin
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic pop_check(input string nm, input logic [31:0] exp);
        chk({nm, "_valid"}, 32'(out_valid), 32'h1);
        chk(nm, out_instr, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] wk(int k);
        return (32'(k) << 20) | 32'h93;
    endfunction

    function automatic logic [31:0] pick_imm();
        int v;
        case ($urandom_range(0, 19))
            0: v = -4097;   1: v = -4096;   2: v = -4095;  3: v = -2049;
            4: v = -2048;   5: v = -1;      6: v = 0;      7: v = 1;
            8: v = 31;      9: v = 32;      10: v = 2047;  11: v = 2048;
            12: v = 4094;   13: v = 4095;   14: v = -(1 << 20);
            15: v = -(1 << 20) - 2;         16: v = (1 << 20) - 2;
            17: v = (1 << 20);              18: v = $urandom_range(0, 63) - 32;
            default: v = int'($urandom);
        endcase
        return 32'(v);
    endfunction

    initial begin
        int npop;
        bit ok;
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_err_pulse", 32'(err_pulse), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // First-word latency and literal encodings
        send(3'd3, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFF_FFFF);
        chk("lat_valid", 32'(out_valid), 32'h1);
        chk("lat_addi", out_instr, 32'hFFF00293);
        pop_check("pop_addi", 32'hFFF00293);
        send(3'd1, 5'd0, 5'd2, 5'd6, 3'b010, 1'b0, 32'd8);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, -32'sd4);
        pop_check("sw", 32'h00612423);
        pop_check("beq", 32'hFE208EE3);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048);
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0);
        pop_check("jal", 32'h001000EF);
        pop_check("sub", 32'h402081B3);

        // Rejects
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3);
        chk("rej_pulse", 32'(err_pulse), 32'h1);
        chk("rej_count1", 32'(err_count), 32'h1);
        chk("rej_no_write", 32'(out_valid), 32'h0);
        step();
        chk("rej_pulse_clr", 32'(err_pulse), 32'h0);
        send(3'd7, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 32'd0);
        chk("rej_count2", 32'(err_count), 32'h2);

        // Fill to full; 5th stalls until a pop frees space
        for (int k = 1; k <= 4; k++) send(3'd3, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'(k));
        chk("full_ready", 32'(in_ready), 32'h0);
        set_cmd(3'd3, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        in_valid = 1'b1;
        step(); step(); step();
        chk("stall_ready", 32'(in_ready), 32'h0);
        chk("stall_head", out_instr, wk(1));
        out_ready = 1'b1;
        npop = 0;
        for (int c = 0; c < 50 && npop < 5; c++) begin
            chk("order", out_instr, wk(npop + 1));
            ok = in_ready && in_valid;
            step();
            npop++;
            if (ok) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("order_drained", 32'(out_valid), 32'h0);
        chk("order_5th_taken", 32'(in_valid), 32'h0);

        // Push+pop at count=2 keeps count, then reset mid-stream
        send(3'd3, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1);
        send(3'd3, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2);
        set_cmd(3'd3, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd3);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("pp_head", out_instr, wk(2));
        send(3'd3, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4);
        chk("pp_cnt3_ready", 32'(in_ready), 32'h1);
        send(3'd3, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        chk("pp_cnt4_ready", 32'(in_ready), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_err", 32'(err_count), 32'h0);
        chk("mid_rst_ready", 32'(in_ready), 32'h1);

        // Saturation
        for (int i = 0; i < EMAX + 5; i++) send(3'd6, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0);
        chk("sat_count", 32'(err_count), 32'(EMAX));
        chk("sat_pulse", 32'(err_pulse), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_class  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_funct3 = 3'($urandom);
            in_f7b5   = 1'($urandom);
            in_imm    = pick_imm();
            out_ready = (i % 1000 < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
